rggen_bus_initiator: RTL and testbench
======================================

RGGEN_BUS_INITIATOR -- requirements
Module: rggen_bus_initiator

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, byte address width driven on bus_if.address.
REQ-002 SHALL have parameter BUS_WIDTH, default 32, data width.
REQ-003 SHALL have parameter STROBE_WIDTH, default BUS_WIDTH/8, strobe width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 0, bus-wait limit in cycles; 0 disables timeout.
REQ-005 SHALL have parameter ERROR_READ_DATA, default '0, read data returned on timeout.
REQ-006 SHALL have port i_clk  input  1  clock; reset is i_rst_n, asynchronous, active-low, on clock i_clk.
REQ-007 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port i_cmd_valid  input  1  command request.
REQ-009 SHALL have port o_cmd_ready  output  1  command accepted when high with i_cmd_valid.
REQ-010 SHALL have port i_cmd_access  input  rggen_access  read/write/posted access type.
REQ-011 SHALL have ports i_cmd_address  input  ADDRESS_WIDTH, i_cmd_write_data  input  BUS_WIDTH, i_cmd_strobe  input  STROBE_WIDTH.
REQ-012 SHALL have port o_rsp_valid  output  1  response available.
REQ-013 SHALL have port i_rsp_ready  input  1  response consumed when high with o_rsp_valid.
REQ-014 SHALL have ports o_rsp_status  output  rggen_status, o_rsp_read_data  output  BUS_WIDTH, o_rsp_timeout  output  1.
REQ-015 SHALL have port bus_if  rggen_bus_if.master  -  initiator side of the register bus.
REQ-016 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, REQUEST, RESPONSE; reset state IDLE.
REQ-018 o_cmd_ready SHALL be (state==IDLE) || (state==RESPONSE && i_rsp_ready).
REQ-019 On command handshake, access/address/write_data/strobe SHALL be registered and state SHALL become REQUEST next cycle.
REQ-020 In REQUEST, bus_if.valid SHALL be 1 and access/address/write_data/strobe SHALL be driven from the registers, stable until completion.
REQ-021 In REQUEST with bus_if.ready=1, bus_if.status and bus_if.read_data SHALL be captured, o_rsp_timeout cleared, and state SHALL become RESPONSE.
REQ-022 Wait counter SHALL clear on REQUEST entry and increment each REQUEST cycle without bus_if.ready; width $clog2(TIMEOUT_CYCLES+1), saturating.
REQ-023 If TIMEOUT_CYCLES>0 and counter reaches TIMEOUT_CYCLES-1 without bus_if.ready, the next state SHALL be RESPONSE with status RGGEN_SLAVE_ERROR, read data ERROR_READ_DATA, o_rsp_timeout=1; bus_if.valid drops.
REQ-024 bus_if.ready in the timeout cycle SHALL take priority over timeout (normal completion).
REQ-025 In RESPONSE, o_rsp_valid SHALL be 1 with registered status/data held until i_rsp_ready.
REQ-026 RESPONSE with i_rsp_ready and i_cmd_valid SHALL go directly to REQUEST with new command; with i_rsp_ready only, to IDLE.
REQ-027 Minimum latency: command handshake to o_rsp_valid = 2 cycles with bus_if.ready in first REQUEST cycle; back-to-back throughput one transfer per 2 cycles.
REQ-028 bus_if.valid SHALL be 0 in IDLE and RESPONSE; bus_if outputs other than valid SHALL retain last values outside REQUEST.

Reset
REQ-029 On i_rst_n low: state IDLE, bus_if.valid 0, o_rsp_valid 0, o_busy 0, o_rsp_timeout 0, o_rsp_status RGGEN_OKAY, all data/address/strobe registers '0, access rggen_access'(0), counter 0.
REQ-030 Reset mid-transaction SHALL abandon the transfer immediately with no response issued.

Structure
REQ-031 rggen_access and rggen_status SHALL come from rggen_rtl_pkg; no new package types required.
REQ-032 Single module; no sub-module; state enum local to the module.
REQ-033 Under RGGEN_ENABLE_SVA, SHALL assert request stability while bus_if.valid && !bus_if.ready (excluding timeout cycle) and o_rsp_valid hold until i_rsp_ready.

Verification
REQ-034 Write 0x10, data 0xDEADBEEF, strobe 0xF, ready after 3 cycles -> bus fields stable 3 cycles, rsp OKAY, timeout 0.
REQ-035 Read 0x04, slave returns 0x12345678 in first cycle -> o_rsp_valid 2 cycles after command, data 0x12345678.
REQ-036 TIMEOUT_CYCLES=4, slave never ready -> bus_if.valid high exactly 4 cycles, rsp SLAVE_ERROR, data ERROR_READ_DATA, timeout 1.
REQ-037 Ready coincides with timeout cycle -> slave status/data returned, timeout 0.
REQ-038 i_rsp_ready held low 5 cycles then command pending on release -> response held 5 cycles, new REQUEST next cycle.
REQ-039 Reset asserted during REQUEST -> bus_if.valid and o_rsp_valid 0 immediately, state IDLE.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus types: access kinds and response status codes.
package rggen_rtl_pkg;

   typedef enum logic [1:0] {
      RGGEN_POSTED_WRITE = 2'b01,
      RGGEN_READ         = 2'b10,
      RGGEN_WRITE        = 2'b11
   } rggen_access;

   typedef enum logic [1:0] {
      RGGEN_OKAY         = 2'b00,
      RGGEN_EXOKAY       = 2'b01,
      RGGEN_SLAVE_ERROR  = 2'b10,
      RGGEN_DECODE_ERROR = 2'b11
   } rggen_status;

endpackage

// File: rtl/rggen_bus_if.sv
// Register bus interface: the initiator drives a request, the target answers with ready/status/data.
interface rggen_bus_if
   import rggen_rtl_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned BUS_WIDTH     = 32
);
   logic                       valid;
   rggen_access                access;
   logic [ADDRESS_WIDTH-1:0]   address;
   logic [BUS_WIDTH-1:0]       write_data;
   logic [BUS_WIDTH/8-1:0]     strobe;
   logic                       ready;
   rggen_status                status;
   logic [BUS_WIDTH-1:0]       read_data;

   modport master (
      output valid, access, address, write_data, strobe,
      input  ready, status, read_data
   );

   modport slave (
      input  valid, access, address, write_data, strobe,
      output ready, status, read_data
   );
endinterface

// File: rtl/rggen_bus_initiator.sv
// Command/response front end driving one register-bus transfer at a time,
// with an optional wait limit that turns a stalled transfer into a slave error.
module rggen_bus_initiator
   import rggen_rtl_pkg::*;
#(
   parameter int unsigned          ADDRESS_WIDTH   = 8,
   parameter int unsigned          BUS_WIDTH       = 32,
   parameter int unsigned          STROBE_WIDTH    = BUS_WIDTH / 8,
   parameter int unsigned          TIMEOUT_CYCLES  = 0,
   parameter logic [BUS_WIDTH-1:0] ERROR_READ_DATA = '0
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_cmd_valid,
   output logic                      o_cmd_ready,
   input  rggen_access               i_cmd_access,
   input  logic [ADDRESS_WIDTH-1:0]  i_cmd_address,
   input  logic [BUS_WIDTH-1:0]      i_cmd_write_data,
   input  logic [STROBE_WIDTH-1:0]   i_cmd_strobe,
   output logic                      o_rsp_valid,
   input  logic                      i_rsp_ready,
   output rggen_status               o_rsp_status,
   output logic [BUS_WIDTH-1:0]      o_rsp_read_data,
   output logic                      o_rsp_timeout,
   rggen_bus_if.master               bus_if,
   output logic                      o_busy
);

   typedef enum logic [1:0] {
      IDLE,
      REQUEST,
      RESPONSE
   } state_e;

   localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
   localparam int unsigned CW           = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] COUNT_MAX    = '1;
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

   state_e                     state;
   rggen_access                access_q;
   logic [ADDRESS_WIDTH-1:0]   address_q;
   logic [BUS_WIDTH-1:0]       write_data_q;
   logic [STROBE_WIDTH-1:0]    strobe_q;
   rggen_status                status_q;
   logic [BUS_WIDTH-1:0]       read_data_q;
   logic                       timeout_q;
   logic [CW-1:0]              wait_count;
   logic                       cmd_accept;
   logic                       timeout_hit;

   // Command acceptance: free when idle, or when the pending response is being consumed.
   always_comb begin
      o_cmd_ready = (state == IDLE) || ((state == RESPONSE) && i_rsp_ready);
      cmd_accept  = i_cmd_valid && o_cmd_ready;
      timeout_hit = TIMEOUT_EN && (wait_count == TIMEOUT_LAST);
   end

   // Transfer sequencing: latch command, wait for the target or the limit, hold the response.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         access_q     <= rggen_access'(2'b00);
         address_q    <= '0;
         write_data_q <= '0;
         strobe_q     <= '0;
         status_q     <= RGGEN_OKAY;
         read_data_q  <= '0;
         timeout_q    <= 1'b0;
         wait_count   <= '0;
      end else begin
         case (state)
            IDLE, RESPONSE: begin
               if (cmd_accept) begin
                  access_q     <= i_cmd_access;
                  address_q    <= i_cmd_address;
                  write_data_q <= i_cmd_write_data;
                  strobe_q     <= i_cmd_strobe;
                  wait_count   <= '0;
                  state        <= REQUEST;
               end else if ((state == RESPONSE) && i_rsp_ready) begin
                  state <= IDLE;
               end
            end
            REQUEST: begin
               // A target answer in the limit cycle wins over the timeout.
               if (bus_if.ready) begin
                  status_q    <= bus_if.status;
                  read_data_q <= bus_if.read_data;
                  timeout_q   <= 1'b0;
                  state       <= RESPONSE;
               end else if (timeout_hit) begin
                  status_q    <= RGGEN_SLAVE_ERROR;
                  read_data_q <= ERROR_READ_DATA;
                  timeout_q   <= 1'b1;
                  state       <= RESPONSE;
               end else if (wait_count != COUNT_MAX) begin
                  wait_count <= wait_count + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus_if.valid      = (state == REQUEST);
   assign bus_if.access     = access_q;
   assign bus_if.address    = address_q;
   assign bus_if.write_data = write_data_q;
   assign bus_if.strobe     = strobe_q;

   assign o_rsp_valid     = (state == RESPONSE);
   assign o_rsp_status    = status_q;
   assign o_rsp_read_data = read_data_q;
   assign o_rsp_timeout   = timeout_q;
   assign o_busy          = (state != IDLE);

`ifdef RGGEN_ENABLE_SVA
   // Request must stay put while the target stalls (the limit cycle may end it).
   assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (bus_if.valid && !bus_if.ready && !timeout_hit) |=>
         (bus_if.valid && $stable(bus_if.access) && $stable(bus_if.address) &&
          $stable(bus_if.write_data) && $stable(bus_if.strobe)));

   // Response must be held unchanged until consumed.
   assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (o_rsp_valid && !i_rsp_ready) |=>
         (o_rsp_valid && $stable(o_rsp_status) && $stable(o_rsp_read_data) &&
          $stable(o_rsp_timeout)));
`endif

endmodule

// File: tb/tb_rggen_bus_initiator.sv
// Bench for rggen_bus_initiator: directed table, hand sequences and randomized transfers.
module tb_rggen_bus_initiator;
   import rggen_rtl_pkg::*;

   localparam int unsigned    TO      = 4;
   localparam logic [31:0]    ERR_DAT = 32'hBADC0DE5;

   logic clk;
   logic rst_n;

   // DUT with a wait limit
   logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_timeout, busy;
   rggen_access cmd_access;
   logic [7:0]  cmd_address;
   logic [31:0] cmd_write_data, rsp_read_data;
   logic [3:0]  cmd_strobe;
   rggen_status rsp_status;

   // DUT with the limit disabled
   logic        c0_cmd_valid, c0_cmd_ready, c0_rsp_valid, c0_rsp_ready, c0_rsp_timeout, c0_busy;
   rggen_access c0_cmd_access;
   logic [7:0]  c0_cmd_address;
   logic [31:0] c0_cmd_write_data, c0_rsp_read_data;
   logic [3:0]  c0_cmd_strobe;
   rggen_status c0_rsp_status;

   rggen_bus_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) bus ();
   rggen_bus_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) bus0 ();

   rggen_bus_initiator #(
      .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .STROBE_WIDTH(4),
      .TIMEOUT_CYCLES(TO), .ERROR_READ_DATA(ERR_DAT)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_access(cmd_access), .i_cmd_address(cmd_address),
      .i_cmd_write_data(cmd_write_data), .i_cmd_strobe(cmd_strobe),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_status(rsp_status), .o_rsp_read_data(rsp_read_data),
      .o_rsp_timeout(rsp_timeout), .bus_if(bus), .o_busy(busy)
   );

   rggen_bus_initiator #(
      .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .STROBE_WIDTH(4)
   ) dut0 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_cmd_valid(c0_cmd_valid), .o_cmd_ready(c0_cmd_ready),
      .i_cmd_access(c0_cmd_access), .i_cmd_address(c0_cmd_address),
      .i_cmd_write_data(c0_cmd_write_data), .i_cmd_strobe(c0_cmd_strobe),
      .o_rsp_valid(c0_rsp_valid), .i_rsp_ready(c0_rsp_ready),
      .o_rsp_status(c0_rsp_status), .o_rsp_read_data(c0_rsp_read_data),
      .o_rsp_timeout(c0_rsp_timeout), .bus_if(bus0), .o_busy(c0_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      rggen_access  acc;
      logic [7:0]   addr;
      logic [31:0]  wdata;
      logic [3:0]   strb;
      int unsigned  wait_n;
      rggen_status  s_status;
      logic [31:0]  s_data;
      rggen_status  e_status;
      logic [31:0]  e_data;
      logic         e_to;
      int unsigned  e_cycles;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference outcome of one transfer whose target answers in REQUEST cycle w (0-based).
   function automatic void model(input int unsigned w, input rggen_status ss, input logic [31:0] sd,
                                 output rggen_status es, output logic [31:0] ed,
                                 output logic eto, output int unsigned ec);
      if (TO != 0 && w >= TO) begin
         es = RGGEN_SLAVE_ERROR; ed = ERR_DAT; eto = 1'b1; ec = TO;
      end else begin
         es = ss; ed = sd; eto = 1'b0; ec = w + 1;
      end
   endfunction

   // One complete transfer on the limited DUT, starting from IDLE.
   task automatic run_txn(input string tag, input vec_t v);
      int unsigned n;
      int unsigned guard;
      int unsigned bad;
      n = 0; guard = 0; bad = 0;
      cmd_access = v.acc; cmd_address = v.addr; cmd_write_data = v.wdata; cmd_strobe = v.strb;
      cmd_valid = 1'b1; rsp_ready = 1'b0;
      #1;
      check({tag, ".cmd_ready_idle"}, cmd_ready, 1);
      step();
      cmd_valid = 1'b0;
      cmd_address = ~v.addr; cmd_write_data = ~v.wdata;
      while (!rsp_valid && guard < 64) begin
         if (bus.valid) begin
            if (bus.access !== v.acc || bus.address !== v.addr ||
                bus.write_data !== v.wdata || bus.strobe !== v.strb) bad++;
            bus.ready = (n == v.wait_n);
            bus.status = v.s_status;
            bus.read_data = v.s_data;
            n++;
         end
         step();
         guard++;
      end
      bus.ready = 1'b0;
      bus.read_data = $urandom;
      check({tag, ".rsp_valid"}, rsp_valid, 1);
      check({tag, ".valid_cycles"}, n, v.e_cycles);
      check({tag, ".bus_fields"}, bad, 0);
      check({tag, ".status"}, rsp_status, v.e_status);
      check({tag, ".data"}, rsp_read_data, v.e_data);
      check({tag, ".timeout"}, rsp_timeout, v.e_to);
      check({tag, ".bus_idle_in_rsp"}, {bus.valid, cmd_ready, busy}, 3'b001);
      step();
      check({tag, ".rsp_hold"}, {rsp_valid, rsp_read_data}, {1'b1, v.e_data});
      rsp_ready = 1'b1;
      #1;
      check({tag, ".cmd_ready_rsp"}, cmd_ready, 1);
      step();
      rsp_ready = 1'b0;
      check({tag, ".back_idle"}, {rsp_valid, busy, bus.valid}, 3'b000);
   endtask

   initial begin
      int unsigned bad;
      int unsigned cnt;
      vec_t v;

      tbl[0] = '{RGGEN_WRITE,        8'h10, 32'hDEADBEEF, 4'hF, 2, RGGEN_OKAY,        32'h0,
                 RGGEN_OKAY,        32'h0,        1'b0, 3};
      tbl[1] = '{RGGEN_READ,         8'h04, 32'h0,        4'h0, 0, RGGEN_OKAY,        32'h12345678,
                 RGGEN_OKAY,        32'h12345678, 1'b0, 1};
      tbl[2] = '{RGGEN_READ,         8'h20, 32'h0,        4'h0, 9, RGGEN_OKAY,        32'h77777777,
                 RGGEN_SLAVE_ERROR, ERR_DAT,      1'b1, 4};
      tbl[3] = '{RGGEN_READ,         8'h30, 32'h0,        4'h0, 3, RGGEN_EXOKAY,      32'hCAFEF00D,
                 RGGEN_EXOKAY,      32'hCAFEF00D, 1'b0, 4};
      tbl[4] = '{RGGEN_POSTED_WRITE, 8'hFF, 32'h55AA55AA, 4'h5, 1, RGGEN_SLAVE_ERROR, 32'h0,
                 RGGEN_SLAVE_ERROR, 32'h0,        1'b0, 2};
      tbl[5] = '{RGGEN_WRITE,        8'h00, 32'h01020304, 4'h3, 4, RGGEN_OKAY,        32'h0,
                 RGGEN_SLAVE_ERROR, ERR_DAT,      1'b1, 4};

      rst_n = 1'b0;
      cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_access = RGGEN_READ;
      cmd_address = '0; cmd_write_data = '0; cmd_strobe = '0;
      c0_cmd_valid = 1'b0; c0_rsp_ready = 1'b0; c0_cmd_access = RGGEN_READ;
      c0_cmd_address = '0; c0_cmd_write_data = '0; c0_cmd_strobe = '0;
      bus.ready = 1'b0; bus.status = RGGEN_OKAY; bus.read_data = '0;
      bus0.ready = 1'b0; bus0.status = RGGEN_OKAY; bus0.read_data = '0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      check("rst.flags", {bus.valid, rsp_valid, busy, rsp_timeout, cmd_ready}, 5'b00001);
      check("rst.rsp", {rsp_status, rsp_read_data}, {RGGEN_OKAY, 32'h0});
      check("rst.bus", {bus.access, bus.address, bus.write_data, bus.strobe}, '0);
      rst_n = 1'b1;
      step();

      // Directed table
      for (int i = 0; i < 6; i++) run_txn($sformatf("tbl%0d", i), tbl[i]);

      // Response held 5 cycles with a command waiting, then direct hand-off to REQUEST
      cmd_access = RGGEN_READ; cmd_address = 8'h08; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      bus.ready = 1'b1; bus.status = RGGEN_OKAY; bus.read_data = 32'h11111111;
      step();
      bus.ready = 1'b0; bus.read_data = 32'h0;
      cmd_access = RGGEN_WRITE; cmd_address = 8'h44; cmd_write_data = 32'hA5A5A5A5;
      cmd_strobe = 4'h3; cmd_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (!(rsp_valid && !cmd_ready && !bus.valid && rsp_read_data == 32'h11111111)) bad++;
         step();
      end
      check("b2b.held5", bad, 0);
      rsp_ready = 1'b1;
      #1;
      check("b2b.cmd_ready", cmd_ready, 1);
      step();
      cmd_valid = 1'b0; rsp_ready = 1'b0;
      check("b2b.new_req", {bus.valid, rsp_valid, bus.address, bus.write_data},
            {1'b1, 1'b0, 8'h44, 32'hA5A5A5A5});
      bus.ready = 1'b1; bus.status = RGGEN_EXOKAY; bus.read_data = 32'h22222222;
      step();
      bus.ready = 1'b0;
      check("b2b.rsp2", {rsp_valid, rsp_status, rsp_read_data}, {1'b1, RGGEN_EXOKAY, 32'h22222222});
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;

      // Randomized transfers against the reference model
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 2))
            0:       v.acc = RGGEN_READ;
            1:       v.acc = RGGEN_WRITE;
            default: v.acc = RGGEN_POSTED_WRITE;
         endcase
         v.addr = 8'($urandom);
         v.wdata = $urandom;
         v.strb = 4'($urandom);
         v.wait_n = $urandom_range(0, 6);
         v.s_status = rggen_status'(2'($urandom));
         v.s_data = $urandom;
         model(v.wait_n, v.s_status, v.s_data, v.e_status, v.e_data, v.e_to, v.e_cycles);
         run_txn($sformatf("rnd%0d", i), v);
      end

      // Limit disabled: a long stall never times out
      c0_cmd_access = RGGEN_READ; c0_cmd_address = 8'h08; c0_cmd_valid = 1'b1;
      step();
      c0_cmd_valid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus0.valid && !c0_rsp_valid) cnt++;
         step();
      end
      check("nolimit.stall", cnt, 12);
      bus0.ready = 1'b1; bus0.status = RGGEN_OKAY; bus0.read_data = 32'h0BADF00D;
      step();
      bus0.ready = 1'b0;
      check("nolimit.rsp", {c0_rsp_valid, c0_rsp_status, c0_rsp_read_data, c0_rsp_timeout},
            {1'b1, RGGEN_OKAY, 32'h0BADF00D, 1'b0});
      c0_rsp_ready = 1'b1;
      step();
      c0_rsp_ready = 1'b0;

      // Reset during REQUEST abandons the transfer
      cmd_access = RGGEN_READ; cmd_address = 8'h3C; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      check("rstmid.in_req", bus.valid, 1);
      rst_n = 1'b0;
      #1;
      check("rstmid.flags", {bus.valid, rsp_valid, busy, cmd_ready}, 4'b0001);
      check("rstmid.addr", bus.address, 8'h00);
      #2;
      rst_n = 1'b1;
      step();
      step();
      check("rstmid.no_rsp", {rsp_valid, busy, bus.valid}, 3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
